// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, LSU and main-memory signals of the shared memory port arbiter.
// master = arbiter side, slave = requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int unsigned BEATS = 4
);
    logic                  fetch_req;
    logic [31:0]           fetch_addr;
    logic                  fetch_flush;
    logic                  fetch_valid;
    logic [32*BEATS-1:0]   fetch_bundle;
    logic                  lsu_req;
    logic                  lsu_we;
    logic [31:0]           lsu_addr;
    logic [31:0]           lsu_wdata;
    logic                  lsu_done;
    logic [31:0]           lsu_rdata;
    logic [31:0]           mem_addr;
    logic                  mem_re;
    logic                  mem_we;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  busy;

    modport master (
        input  fetch_req, fetch_addr, fetch_flush,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata,
        input  mem_rdata,
        output fetch_valid, fetch_bundle,
        output lsu_done, lsu_rdata,
        output mem_addr, mem_re, mem_we, mem_wdata,
        output busy
    );

    modport slave (
        output fetch_req, fetch_addr, fetch_flush,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata,
        output mem_rdata,
        input  fetch_valid, fetch_bundle,
        input  lsu_done, lsu_rdata,
        input  mem_addr, mem_re, mem_we, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit main-memory port between 4-word instruction fetch bundles and
// single-word LSU accesses; LSU has priority, a starvation counter forces fetch progress.
module mem_port_arbiter #(
    parameter int unsigned BEATS        = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.master bus
);
    localparam int unsigned BeatW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int unsigned BundleW = 32 * BEATS;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StFWait,
        StLsuRd,
        StLWait,
        StLsuWr
    } state_e;

    state_e               state_q, state_d;
    logic [BeatW-1:0]     beat_q, beat_d;
    logic [StarveW-1:0]   starve_q, starve_d;
    logic [31:0]          base_q, base_d;
    logic [BundleW-1:0]   buf_q, buf_d;
    logic [BundleW-1:0]   bundle_q, bundle_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic [31:0]          rdata_q, rdata_d;

    logic lsu_elig, fetch_elig, grant_fetch;
    logic unused_addr_bits;

    // A requester whose completion pulse is high is still holding its old request.
    assign lsu_elig   = bus.lsu_req && !done_q;
    assign fetch_elig = bus.fetch_req && !valid_q && !bus.fetch_flush;
    assign unused_addr_bits = ^{bus.fetch_addr[1:0], bus.lsu_addr[1:0]};

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        starve_d    = starve_q;
        base_d      = base_q;
        buf_d       = buf_q;
        bundle_d    = bundle_q;
        valid_d     = 1'b0;
        done_d      = 1'b0;
        rdata_d     = rdata_q;
        grant_fetch = 1'b0;

        unique case (state_q)
            StIdle: begin
                grant_fetch = fetch_elig &&
                              (!lsu_elig || starve_q == StarveW'(STARVE_LIMIT));
                if (grant_fetch) begin
                    state_d  = StFetch;
                    beat_d   = '0;
                    starve_d = '0;
                    base_d   = {bus.fetch_addr[31:2], 2'b00};
                end else if (lsu_elig) begin
                    state_d = bus.lsu_we ? StLsuWr : StLsuRd;
                    // Contested win; starve is below the limit here, so no overflow.
                    if (fetch_elig) starve_d = starve_q + StarveW'(1);
                end
            end
            StLsuWr: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            StLsuRd: state_d = StLWait;
            StLWait: begin
                rdata_d = bus.mem_rdata;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            StFetch: begin
                if (bus.fetch_flush) begin
                    state_d = StIdle;
                end else begin
                    // Data returning now belongs to the beat issued last cycle.
                    for (int i = 0; i < int'(BEATS) - 1; i++) begin
                        if (int'(beat_q) == i + 1) buf_d[32*i +: 32] = bus.mem_rdata;
                    end
                    if (beat_q == BeatW'(BEATS - 1)) state_d = StFWait;
                    else                             beat_d  = beat_q + BeatW'(1);
                end
            end
            StFWait: begin
                state_d = StIdle;
                if (!bus.fetch_flush) begin
                    bundle_d = buf_q;
                    bundle_d[32*(BEATS-1) +: 32] = bus.mem_rdata;
                    valid_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.mem_re    = (state_q == StFetch) || (state_q == StLsuRd);
        bus.mem_we    = (state_q == StLsuWr);
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        unique case (state_q)
            StFetch: bus.mem_addr = base_q + (32'(beat_q) << 2);
            StLsuRd: bus.mem_addr = {bus.lsu_addr[31:2], 2'b00};
            StLsuWr: begin
                bus.mem_addr  = {bus.lsu_addr[31:2], 2'b00};
                bus.mem_wdata = bus.lsu_wdata;
            end
            default: ;
        endcase
    end

    assign bus.busy         = (state_q != StIdle);
    assign bus.fetch_valid  = valid_q;
    assign bus.fetch_bundle = bundle_q;
    assign bus.lsu_done     = done_q;
    assign bus.lsu_rdata    = rdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            beat_q   <= '0;
            starve_q <= '0;
            base_q   <= '0;
            buf_q    <= '0;
            bundle_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            starve_q <= starve_d;
            base_q   <= base_d;
            buf_q    <= buf_d;
            bundle_q <= bundle_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level reference model
// of the shared memory port arbiter.
module tb_mem_port_arbiter;
    localparam int unsigned BEATS        = 4;
    localparam int unsigned STARVE_LIMIT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.BEATS(BEATS)) bus();

    mem_port_arbiter #(
        .BEATS       (BEATS),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Memory: word at address A reads back as A ^ salt, one cycle after mem_re.
    logic [31:0] salt = 32'h0;
    always @(posedge clk) bus.mem_rdata <= bus.mem_re ? (bus.mem_addr ^ salt) : 32'hBAD0BAD0;

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] prev_bundle;

    // Reference model: kind 0 none, 1 store, 2 load, 3 fetch; k = cycle within transaction.
    int          m_kind, m_k, m_starve;
    logic [31:0] m_base, m_rdata, m_prev_addr;
    logic        m_prev_re, m_done, m_valid;
    logic [31:0] m_words [BEATS];
    logic [127:0] m_bundle;
    logic        e_busy, e_re, e_we;
    logic [31:0] e_addr, e_wdata;

    task automatic drive_idle;
        bus.fetch_req = 0; bus.fetch_addr = 0; bus.fetch_flush = 0;
        bus.lsu_req = 0; bus.lsu_we = 0; bus.lsu_addr = 0; bus.lsu_wdata = 0;
    endtask

    task automatic model_reset;
        m_kind = 0; m_k = 0; m_starve = 0; m_base = 0; m_rdata = 0;
        m_done = 0; m_valid = 0; m_bundle = 0; m_prev_re = 0; m_prev_addr = 0;
    endtask

    task automatic model_outputs;
        e_busy  = (m_kind != 0);
        e_re    = (m_kind == 2 && m_k == 1) || (m_kind == 3 && m_k <= int'(BEATS));
        e_we    = (m_kind == 1);
        e_addr  = 32'h0;
        e_wdata = 32'h0;
        if (m_kind == 1) begin
            e_addr  = bus.lsu_addr & ~32'd3;
            e_wdata = bus.lsu_wdata;
        end else if (m_kind == 2 && m_k == 1) begin
            e_addr = bus.lsu_addr & ~32'd3;
        end else if (m_kind == 3 && m_k <= int'(BEATS)) begin
            e_addr = m_base + 32'(4 * (m_k - 1));
        end
    endtask

    task automatic model_step;
        logic [31:0] cur;
        logic le, fe, nd, nv;
        cur = m_prev_re ? (m_prev_addr ^ salt) : 32'hBAD0BAD0;
        m_prev_re = e_re;
        m_prev_addr = e_addr;
        nd = 0; nv = 0;
        if (!rst) begin
            model_reset();
        end else begin
            case (m_kind)
                0: begin
                    le = bus.lsu_req && !m_done;
                    fe = bus.fetch_req && !m_valid && !bus.fetch_flush;
                    if (fe && (!le || m_starve == int'(STARVE_LIMIT))) begin
                        m_kind = 3; m_k = 1; m_starve = 0; m_base = bus.fetch_addr & ~32'd3;
                    end else if (le) begin
                        m_kind = bus.lsu_we ? 1 : 2; m_k = 1;
                        if (fe) m_starve++;
                    end
                end
                1: begin m_kind = 0; nd = 1; end
                2: begin
                    if (m_k == 1) m_k = 2;
                    else begin m_rdata = cur; nd = 1; m_kind = 0; end
                end
                default: begin
                    if (bus.fetch_flush) m_kind = 0;
                    else begin
                        if (m_k >= 2) m_words[m_k-2] = cur;
                        if (m_k == int'(BEATS) + 1) begin
                            for (int j = 0; j < int'(BEATS); j++) m_bundle[32*j +: 32] = m_words[j];
                            nv = 1; m_kind = 0;
                        end else m_k++;
                    end
                end
            endcase
            m_done = nd;
            m_valid = nv;
        end
    endtask

    task automatic test_reset;
        logic [228:0] obs;
        rst = 0;
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        obs = {bus.busy, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.fetch_valid,
               bus.fetch_bundle, bus.lsu_done, bus.lsu_rdata};
        n_cmp++;
        if (obs !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h want all zero", obs);
        end
        @(negedge clk); rst = 1;
    endtask

    task automatic test_store;
        @(negedge clk);
        bus.lsu_req = 1; bus.lsu_we = 1; bus.lsu_addr = 32'h10; bus.lsu_wdata = 32'hDEADBEEF;
        #1; n_cmp++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL store_c0_busy: got %b want 0", bus.busy); end
        @(negedge clk); #1; n_cmp++;
        if ({bus.mem_we, bus.mem_re, bus.busy, bus.lsu_done, bus.mem_addr, bus.mem_wdata}
            !== {4'b1010, 32'h10, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL store_c1: got we%b re%b busy%b done%b %h %h want 1010 10 deadbeef",
                              bus.mem_we, bus.mem_re, bus.busy, bus.lsu_done, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk); #1; n_cmp++;
        if ({bus.lsu_done, bus.busy, bus.mem_we} !== 3'b100) begin
            n_err++; $display("FAIL store_c2_done: got done%b busy%b we%b want 100", bus.lsu_done, bus.busy, bus.mem_we);
        end
        @(negedge clk); bus.lsu_req = 0; #1; n_cmp++;
        if ({bus.lsu_done, bus.busy} !== 2'b00) begin
            n_err++; $display("FAIL store_no_regrant: got done%b busy%b want 00", bus.lsu_done, bus.busy);
        end
    endtask

    task automatic test_fetch;
        logic [127:0] exp_b;
        exp_b = 128'h0000010C_00000108_00000104_00000100;
        salt = 0;
        @(negedge clk); bus.fetch_req = 1; bus.fetch_addr = 32'h100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1; n_cmp++;
            if ({bus.mem_re, bus.mem_we, bus.mem_addr} !== {2'b10, 32'h100 + 32'(4 * i)}) begin
                n_err++; $display("FAIL fetch_beat%0d: got re%b we%b %h want 10 %h", i, bus.mem_re,
                                  bus.mem_we, bus.mem_addr, 32'h100 + 32'(4 * i));
            end
        end
        @(negedge clk); #1; n_cmp++;
        if ({bus.busy, bus.mem_re, bus.fetch_valid} !== 3'b100) begin
            n_err++; $display("FAIL fetch_wait: got busy%b re%b valid%b want 100", bus.busy, bus.mem_re, bus.fetch_valid);
        end
        @(negedge clk); #1; n_cmp++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_bundle !== exp_b) begin
            n_err++; $display("FAIL fetch_valid: got %b %h want 1 %h", bus.fetch_valid, bus.fetch_bundle, exp_b);
        end
        @(negedge clk); bus.fetch_req = 0; #1; n_cmp++;
        if ({bus.fetch_valid, bus.busy} !== 2'b00 || bus.fetch_bundle !== exp_b) begin
            n_err++; $display("FAIL fetch_hold: got valid%b busy%b %h want 00 %h", bus.fetch_valid, bus.busy, bus.fetch_bundle, exp_b);
        end
    endtask

    task automatic test_load;
        salt = 32'h1234_0000;
        @(negedge clk); bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_addr = 32'h22;
        @(negedge clk); #1; n_cmp++;
        if ({bus.mem_re, bus.mem_we, bus.mem_addr} !== {2'b10, 32'h20}) begin
            n_err++; $display("FAIL load_issue: got re%b we%b %h want 10 00000020", bus.mem_re, bus.mem_we, bus.mem_addr);
        end
        @(negedge clk); #1; n_cmp++;
        if ({bus.busy, bus.mem_re, bus.lsu_done} !== 3'b100) begin
            n_err++; $display("FAIL load_wait: got busy%b re%b done%b want 100", bus.busy, bus.mem_re, bus.lsu_done);
        end
        @(negedge clk); #1; n_cmp++;
        if (bus.lsu_done !== 1'b1 || bus.lsu_rdata !== 32'h1234_0020) begin
            n_err++; $display("FAIL load_done: got %b %h want 1 12340020", bus.lsu_done, bus.lsu_rdata);
        end
        @(negedge clk); bus.lsu_req = 0; #1; n_cmp++;
        if (bus.lsu_done !== 1'b0 || bus.lsu_rdata !== 32'h1234_0020) begin
            n_err++; $display("FAIL load_hold: got %b %h want 0 12340020", bus.lsu_done, bus.lsu_rdata);
        end
    endtask

    task automatic test_starve;
        bit got;
        salt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.fetch_req = 1; bus.fetch_addr = 32'h300;
            bus.lsu_req = 1; bus.lsu_we = 1; bus.lsu_addr = 32'h40 + 32'(4 * i); bus.lsu_wdata = 32'(i);
            @(negedge clk); if (i == 3) bus.lsu_req = 0; #1; n_cmp++;
            if (i < 3 && {bus.mem_we, bus.mem_re} !== 2'b10) begin
                n_err++; $display("FAIL starve_lsu_win%0d: got we%b re%b want 10", i, bus.mem_we, bus.mem_re);
            end else if (i == 3 && {bus.mem_we, bus.mem_re, bus.mem_addr} !== {2'b01, 32'h300}) begin
                n_err++; $display("FAIL starve_fetch_forced: got we%b re%b %h want 01 00000300",
                                  bus.mem_we, bus.mem_re, bus.mem_addr);
            end
            if (i < 3) begin
                @(negedge clk); bus.fetch_req = 0; #1; n_cmp++;
                if (bus.lsu_done !== 1'b1) begin
                    n_err++; $display("FAIL starve_done%0d: got %b want 1", i, bus.lsu_done);
                end
            end
        end
        got = 0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk); #1;
            if (bus.fetch_valid === 1'b1) got = 1;
        end
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL starve_fetch_complete: got no fetch_valid want pulse"); end
        @(negedge clk); bus.fetch_req = 0;
        @(negedge clk); bus.fetch_req = 1; bus.lsu_req = 1; bus.lsu_we = 1;
        @(negedge clk); #1; n_cmp++;
        if ({bus.mem_we, bus.mem_re} !== 2'b10) begin
            n_err++; $display("FAIL starve_cleared: got we%b re%b want 10", bus.mem_we, bus.mem_re);
        end
        @(negedge clk); drive_idle();
        repeat (2) @(negedge clk);
        prev_bundle = 128'h0000030C_00000308_00000304_00000300;
    endtask

    task automatic test_flush;
        salt = 32'h0F0F_0000;
        @(negedge clk); bus.fetch_req = 1; bus.fetch_addr = 32'h200;
        repeat (2) @(negedge clk);
        @(negedge clk); bus.fetch_flush = 1; bus.fetch_req = 0; #1; n_cmp++;
        if (bus.mem_re !== 1'b1) begin n_err++; $display("FAIL flush_third_beat: got re%b want 1", bus.mem_re); end
        @(negedge clk); bus.fetch_flush = 0; #1; n_cmp++;
        if ({bus.busy, bus.mem_re} !== 2'b00) begin
            n_err++; $display("FAIL flush_idle: got busy%b re%b want 00", bus.busy, bus.mem_re);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1; n_cmp++;
            if (bus.fetch_valid !== 1'b0 || bus.fetch_bundle !== prev_bundle) begin
                n_err++; $display("FAIL flush_no_valid%0d: got %b %h want 0 %h", c, bus.fetch_valid, bus.fetch_bundle, prev_bundle);
            end
        end
        @(negedge clk); bus.fetch_req = 1; bus.fetch_addr = 32'h280;
        repeat (4) @(negedge clk);
        @(negedge clk); bus.fetch_flush = 1; bus.fetch_req = 0; #1; n_cmp++;
        if ({bus.busy, bus.mem_re} !== 2'b10) begin
            n_err++; $display("FAIL flush_fwait_state: got busy%b re%b want 10", bus.busy, bus.mem_re);
        end
        @(negedge clk); bus.fetch_flush = 0; #1; n_cmp++;
        if ({bus.fetch_valid, bus.busy} !== 2'b00 || bus.fetch_bundle !== prev_bundle) begin
            n_err++; $display("FAIL flush_fwait_suppress: got valid%b busy%b %h want 00 %h",
                              bus.fetch_valid, bus.busy, bus.fetch_bundle, prev_bundle);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_a [4];
        logic [127:0] exp_b;
        exp_a[0] = 32'hFFFFFFF8; exp_a[1] = 32'hFFFFFFFC; exp_a[2] = 32'h0; exp_a[3] = 32'h4;
        exp_b = {32'h4, 32'h0, 32'hFFFFFFFC, 32'hFFFFFFF8};
        salt = 0;
        @(negedge clk); bus.fetch_req = 1; bus.fetch_addr = 32'hFFFFFFF8;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1; n_cmp++;
            if (bus.mem_re !== 1'b1 || bus.mem_addr !== exp_a[i]) begin
                n_err++; $display("FAIL wrap_beat%0d: got re%b %h want 1 %h", i, bus.mem_re, bus.mem_addr, exp_a[i]);
            end
        end
        repeat (2) @(negedge clk);
        #1; n_cmp++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_bundle !== exp_b) begin
            n_err++; $display("FAIL wrap_bundle: got %b %h want 1 %h", bus.fetch_valid, bus.fetch_bundle, exp_b);
        end
        @(negedge clk); bus.fetch_req = 0;
    endtask

    task automatic test_reset_mid;
        logic [228:0] obs;
        salt = 32'h00AB_0000;
        @(negedge clk); bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_addr = 32'h40;
        @(negedge clk);
        @(negedge clk); rst = 0; #1; n_cmp++;
        if ({bus.busy, bus.mem_re} !== 2'b10) begin
            n_err++; $display("FAIL rstmid_lwait: got busy%b re%b want 10", bus.busy, bus.mem_re);
        end
        @(negedge clk); rst = 1; bus.lsu_addr = 32'h44; #1;
        obs = {bus.busy, bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.fetch_valid,
               bus.fetch_bundle, bus.lsu_done, bus.lsu_rdata};
        n_cmp++;
        if (obs !== '0) begin n_err++; $display("FAIL rstmid_outputs: got %h want all zero", obs); end
        @(negedge clk); #1; n_cmp++;
        if (bus.mem_re !== 1'b1 || bus.mem_addr !== 32'h44) begin
            n_err++; $display("FAIL rstmid_reload: got re%b %h want 1 00000044", bus.mem_re, bus.mem_addr);
        end
        repeat (2) @(negedge clk);
        #1; n_cmp++;
        if (bus.lsu_done !== 1'b1 || bus.lsu_rdata !== 32'h00AB_0044) begin
            n_err++; $display("FAIL rstmid_clean_load: got %b %h want 1 00ab0044", bus.lsu_done, bus.lsu_rdata);
        end
        @(negedge clk); drive_idle();
    endtask

    task automatic test_random;
        bit lsu_drop, fetch_drop;
        salt = $urandom;
        @(negedge clk); rst = 0; drive_idle();
        @(negedge clk);
        model_reset();
        lsu_drop = 0; fetch_drop = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 149) != 0);
            if (lsu_drop) bus.lsu_req = 0;
            if (!bus.lsu_req && $urandom_range(0, 3) == 0) begin
                bus.lsu_req = 1; bus.lsu_we = $urandom_range(0, 1) == 1;
                bus.lsu_addr = $urandom; bus.lsu_wdata = $urandom;
            end
            bus.fetch_flush = ($urandom_range(0, 24) == 0);
            if (fetch_drop || bus.fetch_flush) bus.fetch_req = 0;
            if (!bus.fetch_req && $urandom_range(0, 3) == 0) begin
                bus.fetch_req = 1;
                bus.fetch_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                                             : $urandom;
            end
            #1;
            model_outputs();
            n_cmp += 9;
            if (bus.busy !== e_busy) begin
                n_err++; $display("FAIL rnd_busy c%0d: got %b want %b", c, bus.busy, e_busy); end
            if (bus.mem_re !== e_re) begin
                n_err++; $display("FAIL rnd_mem_re c%0d: got %b want %b", c, bus.mem_re, e_re); end
            if (bus.mem_we !== e_we) begin
                n_err++; $display("FAIL rnd_mem_we c%0d: got %b want %b", c, bus.mem_we, e_we); end
            if (bus.mem_addr !== e_addr) begin
                n_err++; $display("FAIL rnd_mem_addr c%0d: got %h want %h", c, bus.mem_addr, e_addr); end
            if (bus.mem_wdata !== e_wdata) begin
                n_err++; $display("FAIL rnd_mem_wdata c%0d: got %h want %h", c, bus.mem_wdata, e_wdata); end
            if (bus.lsu_done !== m_done) begin
                n_err++; $display("FAIL rnd_lsu_done c%0d: got %b want %b", c, bus.lsu_done, m_done); end
            if (bus.lsu_rdata !== m_rdata) begin
                n_err++; $display("FAIL rnd_lsu_rdata c%0d: got %h want %h", c, bus.lsu_rdata, m_rdata); end
            if (bus.fetch_valid !== m_valid) begin
                n_err++; $display("FAIL rnd_fetch_valid c%0d: got %b want %b", c, bus.fetch_valid, m_valid); end
            if (bus.fetch_bundle !== m_bundle) begin
                n_err++; $display("FAIL rnd_fetch_bundle c%0d: got %h want %h", c, bus.fetch_bundle, m_bundle); end
            lsu_drop = m_done;
            fetch_drop = m_valid;
            model_step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0;
        drive_idle();
        test_reset();
        test_store();
        test_fetch();
        test_load();
        test_starve();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
